// File: rtl/arm_shifter_seq_if.sv
// rtl/arm_shifter_seq_if.sv - operand/result handshake bundle for the iterative ARM shifter.
interface arm_shifter_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op_type;
  logic [WIDTH-1:0] op_value;
  logic [7:0]       op_amount;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             out_err;

  modport master (
    output in_valid, op_type, op_value, op_amount, carry_in, out_ready,
    input  in_ready, out_valid, result, carry_out, out_err
  );

  modport slave (
    input  in_valid, op_type, op_value, op_amount, carry_in, out_ready,
    output in_ready, out_valid, result, carry_out, out_err
  );
endinterface

// File: rtl/arm_shifter_seq.sv
// rtl/arm_shifter_seq.sv - multi-cycle ARM shifter operand unit, at most STEP bits per clock.
module arm_shifter_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8
) (
  input logic               clk,
  input logic               reset,
  arm_shifter_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int RW = $clog2(WIDTH + 2);
  localparam int AW = $clog2(WIDTH);

  localparam logic [2:0] OP_LSL = 3'd0;
  localparam logic [2:0] OP_LSR = 3'd1;
  localparam logic [2:0] OP_ASR = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
  localparam logic [2:0] OP_RRX = 3'd4;
  localparam logic [2:0] OP_IMM = 3'd5;

  state_t           state_q;
  logic [WIDTH-1:0] val_q;
  logic [2:0]       type_q;
  logic             carry_q;
  logic             err_q;
  logic [RW-1:0]    rem_q;

  logic             accept;
  logic [WIDTH-1:0] ld_val_d;
  logic             ld_carry_d;
  logic             ld_err_d;
  logic [RW-1:0]    ld_rem_d;
  logic [AW-1:0]    ror_r;
  logic [AW-1:0]    imm_r;

  logic [RW-1:0]    step_s;
  logic [WIDTH-1:0] lsl_pre;
  logic [WIDTH-1:0] rsh_pre;
  logic [WIDTH-1:0] sh_val_d;
  logic             sh_carry_d;

  assign bus.in_ready  = ~reset & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = val_q;
  assign bus.carry_out = carry_q;
  assign bus.out_err   = err_q;

  // Everything the shift loop needs is decided here, once, on the accept edge.
  always_comb begin
    ld_val_d   = bus.op_value;
    ld_carry_d = bus.carry_in;
    ld_err_d   = 1'b0;
    ld_rem_d   = '0;
    ror_r      = bus.op_amount[AW-1:0];
    imm_r      = AW'({bus.op_amount[3:0], 1'b0});
    case (bus.op_type)
      OP_LSL, OP_LSR, OP_ASR: begin
        if (bus.op_amount > 8'(WIDTH + 1)) ld_rem_d = RW'(WIDTH + 1);
        else                               ld_rem_d = RW'(bus.op_amount);
      end
      OP_ROR: begin
        ld_rem_d = RW'(ror_r);
        if ((bus.op_amount != 8'd0) && (ror_r == '0)) ld_carry_d = bus.op_value[WIDTH-1];
      end
      OP_IMM: begin
        ld_val_d = WIDTH'(bus.op_value[7:0]);
        ld_rem_d = RW'(imm_r);
        // A full-turn rotate of a zero-extended byte leaves the top bit, which is 0.
        if ((bus.op_amount[3:0] != 4'd0) && (imm_r == '0)) ld_carry_d = 1'b0;
      end
      OP_RRX: begin
        ld_val_d   = {bus.carry_in, bus.op_value[WIDTH-1:1]};
        ld_carry_d = bus.op_value[0];
      end
      default: ld_err_d = 1'b1;
    endcase
  end

  always_comb begin
    step_s  = (rem_q > RW'(STEP)) ? RW'(STEP) : rem_q;
    lsl_pre = val_q << (step_s - RW'(1));
    rsh_pre = val_q >> (step_s - RW'(1));
    case (type_q)
      OP_LSL: begin
        sh_val_d   = val_q << step_s;
        sh_carry_d = lsl_pre[WIDTH-1];
      end
      OP_LSR: begin
        sh_val_d   = val_q >> step_s;
        sh_carry_d = rsh_pre[0];
      end
      OP_ASR: begin
        sh_val_d   = $signed(val_q) >>> step_s;
        sh_carry_d = rsh_pre[0];
      end
      default: begin
        sh_val_d   = (val_q >> step_s) | (val_q << (RW'(WIDTH) - step_s));
        sh_carry_d = rsh_pre[0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      type_q  <= 3'd0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= '0;
    end else if (accept) begin
      val_q   <= ld_val_d;
      type_q  <= bus.op_type;
      carry_q <= ld_carry_d;
      err_q   <= ld_err_d;
      rem_q   <= ld_rem_d;
      state_q <= (ld_rem_d != '0) ? SHIFT : DONE;
    end else begin
      case (state_q)
        SHIFT: begin
          val_q   <= sh_val_d;
          carry_q <= sh_carry_d;
          rem_q   <= rem_q - step_s;
          if (rem_q == step_s) state_q <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule
